// File: rtl/gpio_multi.sv
// Multi-pin GPIO: register-mapped mode/data/set/clr/interrupt control with edge-detect status.
// Define GPIO_MULTI_SYNC2_EN for a two-flop input synchroniser (default: single sampling flop).
module gpio_multi #(
  parameter int unsigned NPIN = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [31:0]     addr_i,
  input  logic [31:0]     data_i,
  output logic [31:0]     data_o,
  input  logic [NPIN-1:0] io_pin_i,
  output logic [NPIN-1:0] io_out_o,
  output logic [NPIN-1:0] io_oe_o,
  output logic            irq_o
);

  localparam int unsigned MW = 2 * NPIN;

  localparam logic [4:0] A_MODE = 5'h00;
  localparam logic [4:0] A_DATA = 5'h04;
  localparam logic [4:0] A_SET  = 5'h08;
  localparam logic [4:0] A_CLR  = 5'h0C;
  localparam logic [4:0] A_IEN  = 5'h10;
  localparam logic [4:0] A_STAT = 5'h14;
  localparam logic [4:0] A_EDGE = 5'h18;

  logic [MW-1:0]   mode_q;
  logic [NPIN-1:0] out_q;
  logic [NPIN-1:0] ien_q;
  logic [NPIN-1:0] stat_q;
  logic [NPIN-1:0] edge_q;
  logic [NPIN-1:0] in_s;
  logic [NPIN-1:0] in_prev_q;

  logic [NPIN-1:0] in_mode_c;
  logic [NPIN-1:0] oe_mode_c;
  logic [NPIN-1:0] edge_det_c;
  logic [NPIN-1:0] w1c_c;
  logic [NPIN-1:0] rd_data_c;
  logic [4:0]      offs_c;

  logic unused_bits;
  assign unused_bits = &{1'b0, addr_i[31:5], data_i};

  assign offs_c = addr_i[4:0];

  // Input synchroniser; in_s is the last stage seen by the edge detector and DATA reads
`ifdef GPIO_MULTI_SYNC2_EN
  logic [NPIN-1:0] meta_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= '0;
      in_s   <= '0;
    end else begin
      meta_q <= io_pin_i;
      in_s   <= meta_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_s <= '0;
    end else begin
      in_s <= io_pin_i;
    end
  end
`endif

  // Per-pin mode decode: 01 drives the pad, 10 samples it, 00/11 leave it floating
  always_comb begin
    in_mode_c = '0;
    oe_mode_c = '0;
    for (int i = 0; i < int'(NPIN); i++) begin
      in_mode_c[i] = (mode_q[2*i +: 2] == 2'b10);
      oe_mode_c[i] = (mode_q[2*i +: 2] == 2'b01);
    end
  end

  // Polarity select: in_s ^ edge gives 1 for rising when EDGE=0, falling when EDGE=1
  assign edge_det_c = (in_s ^ in_prev_q) & in_mode_c & (in_s ^ edge_q);
  assign w1c_c      = (we_i && offs_c == A_STAT) ? data_i[NPIN-1:0] : '0;
  assign rd_data_c  = (in_mode_c & in_s) | (~in_mode_c & out_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q    <= '0;
      out_q     <= '0;
      ien_q     <= '0;
      stat_q    <= '0;
      edge_q    <= '0;
      in_prev_q <= '0;
    end else begin
      if (we_i) begin
        case (offs_c)
          A_MODE:  mode_q <= data_i[MW-1:0];
          A_DATA:  out_q  <= data_i[NPIN-1:0];
          A_SET:   out_q  <= out_q | data_i[NPIN-1:0];
          A_CLR:   out_q  <= out_q & ~data_i[NPIN-1:0];
          A_IEN:   ien_q  <= data_i[NPIN-1:0];
          A_EDGE:  edge_q <= data_i[NPIN-1:0];
          default: ;
        endcase
      end
      // A new edge wins over a simultaneous clear of the same bit
      stat_q    <= (stat_q & ~w1c_c) | edge_det_c;
      in_prev_q <= in_s;
    end
  end

  always_comb begin
    data_o = '0;
    if (rst) begin
      case (offs_c)
        A_MODE:  data_o = 32'(mode_q);
        A_DATA:  data_o = 32'(rd_data_c);
        A_IEN:   data_o = 32'(ien_q);
        A_STAT:  data_o = 32'(stat_q);
        A_EDGE:  data_o = 32'(edge_q);
        default: data_o = '0;
      endcase
    end
  end

  assign io_oe_o  = rst ? oe_mode_c : '0;
  assign io_out_o = rst ? out_q : '0;
  assign irq_o    = rst & (|(stat_q & ien_q));

endmodule

// File: tb/tb_gpio_multi.sv
// Directed self-checking bench for gpio_multi (NPIN=8), latency follows GPIO_MULTI_SYNC2_EN.
module tb_gpio_multi;

  localparam int unsigned NPIN = 8;
`ifdef GPIO_MULTI_SYNC2_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  localparam logic [31:0] A_MODE = 32'h00;
  localparam logic [31:0] A_DATA = 32'h04;
  localparam logic [31:0] A_SET  = 32'h08;
  localparam logic [31:0] A_CLR  = 32'h0C;
  localparam logic [31:0] A_IEN  = 32'h10;
  localparam logic [31:0] A_STAT = 32'h14;
  localparam logic [31:0] A_EDGE = 32'h18;
  localparam logic [31:0] A_NONE = 32'h1C;

  logic            clk = 1'b0;
  logic            rst;
  logic            we_i;
  logic [31:0]     addr_i;
  logic [31:0]     data_i;
  logic [31:0]     data_o;
  logic [NPIN-1:0] io_pin_i;
  logic [NPIN-1:0] io_out_o;
  logic [NPIN-1:0] io_oe_o;
  logic            irq_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] rdv;

  gpio_multi #(.NPIN(NPIN)) dut (
    .clk      (clk),
    .rst      (rst),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .data_o   (data_o),
    .io_pin_i (io_pin_i),
    .io_out_o (io_out_o),
    .io_oe_o  (io_oe_o),
    .irq_o    (irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Called right after a negedge; returns right after the following negedge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we_i   = 1'b1;
    addr_i = a;
    data_i = d;
    @(negedge clk);
    we_i   = 1'b0;
    data_i = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr_i = a;
    #1;
    d = data_o;
  endtask

  initial begin
    rst      = 1'b0;
    we_i     = 1'b0;
    addr_i   = '0;
    data_i   = '0;
    io_pin_i = '0;
    repeat (2) @(negedge clk);

    // Reset state and write-during-reset
    rd(A_MODE, rdv); check("rst_data_o", rdv, 32'h0);
    check("rst_oe", 32'(io_oe_o), 32'h0);
    check("rst_out", 32'(io_out_o), 32'h0);
    check("rst_irq", 32'(irq_o), 32'h0);
    wr(A_MODE, 32'h1);
    rst = 1'b1;
    rd(A_MODE, rdv); check("wr_in_rst", rdv, 32'h0);

    // Output path, SET/CLR
    wr(A_MODE, 32'h0001);
    wr(A_DATA, 32'h01);
    check("oe_pin0", 32'(io_oe_o), 32'h01);
    check("out_pin0", 32'(io_out_o), 32'h01);
    wr(A_SET, 32'h80);
    wr(A_CLR, 32'h01);
    check("out_setclr", 32'(io_out_o), 32'h80);
    rd(A_SET, rdv); check("set_rd0", rdv, 32'h0);

    // Output -> input mode change with stable pin: no edge
    wr(A_MODE, 32'h0041);
    io_pin_i = 8'h08;
    repeat (3) @(negedge clk);
    wr(A_MODE, 32'h0081);
    repeat (3) @(negedge clk);
    rd(A_STAT, rdv); check("mode_chg_no_edge", rdv, 32'h0);
    io_pin_i = 8'h00;
    repeat (4) @(negedge clk);

    // Rising edge latency, irq, DATA read of input pin
    wr(A_IEN, 32'h08);
    wr(A_EDGE, 32'h00);
    io_pin_i = 8'h08;
    repeat (LAT - 1) @(negedge clk);
    rd(A_STAT, rdv); check("stat_early", rdv, 32'h0);
    check("irq_early", 32'(irq_o), 32'h0);
    @(negedge clk);
    rd(A_STAT, rdv); check("stat_rise", rdv, 32'h08);
    check("irq_rise", 32'(irq_o), 32'h1);
    rd(A_DATA, rdv); check("data_rd_in", rdv, 32'h88);

    // W1C without edge
    wr(A_STAT, 32'h08);
    rd(A_STAT, rdv); check("w1c_clear", rdv, 32'h0);
    check("irq_cleared", 32'(irq_o), 32'h0);

    // Falling-edge select
    io_pin_i = 8'h00;
    repeat (4) @(negedge clk);
    rd(A_STAT, rdv); check("fall_ign_edge0", rdv, 32'h0);
    wr(A_EDGE, 32'h08);
    io_pin_i = 8'h08;
    repeat (4) @(negedge clk);
    rd(A_STAT, rdv); check("rise_ign_edge1", rdv, 32'h0);
    io_pin_i = 8'h00;
    repeat (LAT) @(negedge clk);
    rd(A_STAT, rdv); check("fall_set", rdv, 32'h08);

    // W1C coincident with a new edge keeps the bit
    io_pin_i = 8'h08;
    repeat (4) @(negedge clk);
    io_pin_i = 8'h00;
    repeat (LAT - 1) @(negedge clk);
    wr(A_STAT, 32'h08);
    rd(A_STAT, rdv); check("w1c_vs_edge", rdv, 32'h08);
    wr(A_STAT, 32'h08);
    rd(A_STAT, rdv); check("w1c_after", rdv, 32'h0);

    // Width masking and unmapped offset
    wr(A_MODE, 32'hFFFF_FFFF);
    rd(A_MODE, rdv); check("mode_mask", rdv, 32'h0000_FFFF);
    check("rsvd_oe", 32'(io_oe_o), 32'h0);
    wr(A_DATA, 32'hFFFF_FFFF);
    rd(A_DATA, rdv); check("data_mask", rdv, 32'h0000_00FF);
    wr(A_IEN, 32'hFFFF_FFFF);
    rd(A_IEN, rdv); check("ien_mask", rdv, 32'h0000_00FF);
    wr(A_NONE, 32'hFFFF_FFFF);
    rd(A_NONE, rdv); check("unmapped_rd", rdv, 32'h0);

    // Mid-operation reset
    wr(A_MODE, 32'h0080);
    wr(A_EDGE, 32'h00);
    io_pin_i = 8'h08;
    repeat (LAT) @(negedge clk);
    rd(A_STAT, rdv); check("pre_rst_stat", rdv, 32'h08);
    check("pre_rst_irq", 32'(irq_o), 32'h1);
    rst = 1'b0;
    #1;
    check("rst_mid_oe", 32'(io_oe_o), 32'h0);
    check("rst_mid_out", 32'(io_out_o), 32'h0);
    check("rst_mid_irq", 32'(irq_o), 32'h0);
    @(negedge clk);
    io_pin_i = 8'h00;
    @(negedge clk);
    io_pin_i = 8'hFF;
    @(negedge clk);
    rd(A_STAT, rdv); check("rst_mid_data_o", rdv, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rd(A_STAT, rdv); check("rel_first_cycle", rdv, 32'h0);
    repeat (2) @(negedge clk);
    rd(A_MODE, rdv); check("rel_mode", rdv, 32'h0);
    rd(A_DATA, rdv); check("rel_data", rdv, 32'h0);
    wr(A_MODE, 32'h0080);
    repeat (3) @(negedge clk);
    rd(A_STAT, rdv); check("rel_stat", rdv, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
